// File: rtl/micro_maze_pkg.sv
// Shared constants for the micro_maze tile: maze ROM, start/goal cells and pin indices.
package micro_maze_pkg;

  // Row y, bit x = cell (x,y); 1 = wall.
  localparam logic [0:7][7:0] MAZE_ROM = {8'hF0, 8'hF7, 8'h07, 8'h7F,
                                          8'h7F, 8'h01, 8'hFD, 8'h01};

  localparam logic [2:0] START_X = 3'd0;
  localparam logic [2:0] START_Y = 3'd0;
  localparam logic [2:0] GOAL_X  = 3'd7;
  localparam logic [2:0] GOAL_Y  = 3'd7;

  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned STATUS_SEL = 4;
  localparam int unsigned ROWSEL_LSB = 5;

  localparam logic [6:0] MOVES_MAX = 7'd127;

endpackage

// File: rtl/micro_maze_if.sv
// Tile pin bundle for micro_maze: 8 user inputs and 8 user outputs.
interface micro_maze_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  modport master (output ui_in, input uo_out);
  modport slave  (input ui_in, output uo_out);
endinterface

// File: rtl/micro_maze_btn_sync_edge.sv
// Multi-stage button synchronizer with rising-edge detect on the synced level.
module btn_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WIDTH       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/micro_maze.sv
// Micro maze game top: movement/collision, win/restart and row/status display mux.
// Define BUMP_PENALTY_EN to count blocked moves toward the move counter.
module micro_maze
  import micro_maze_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst_n,
  micro_maze_if.slave  io
);

  logic [3:0] btn_level, btn_rise;
  logic [2:0] px_q, px_d, py_q, py_d, tx, ty, row;
  logic [6:0] moves_q, moves_d, moves_inc;
  logic       won_q, won_d;
  logic       restart, single, in_bounds, open_cell;
  logic [7:0] marker;

  btn_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (4)
  ) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (io.ui_in[BTN_RIGHT:BTN_UP]),
    .level (btn_level),
    .rise  (btn_rise)
  );

  always_comb begin
    px_d      = px_q;
    py_d      = py_q;
    moves_d   = moves_q;
    won_d     = won_q;
    tx        = px_q;
    ty        = py_q;
    in_bounds = 1'b0;
    restart   = btn_level[BTN_UP] & btn_level[BTN_DOWN];
    single    = $onehot(btn_rise) & ~won_q;
    moves_inc = (moves_q == MOVES_MAX) ? moves_q : moves_q + 7'd1;

    if (btn_rise[BTN_UP]) begin
      in_bounds = (py_q != 3'd0);
      ty        = py_q - 3'd1;
    end else if (btn_rise[BTN_DOWN]) begin
      in_bounds = (py_q != 3'd7);
      ty        = py_q + 3'd1;
    end else if (btn_rise[BTN_LEFT]) begin
      in_bounds = (px_q != 3'd0);
      tx        = px_q - 3'd1;
    end else if (btn_rise[BTN_RIGHT]) begin
      in_bounds = (px_q != 3'd7);
      tx        = px_q + 3'd1;
    end
    open_cell = ~MAZE_ROM[ty][tx];

    // Restart is level-driven and wins over any simultaneous move.
    if (restart) begin
      px_d    = START_X;
      py_d    = START_Y;
      moves_d = '0;
      won_d   = 1'b0;
    end else if (single) begin
      if (in_bounds && open_cell) begin
        px_d    = tx;
        py_d    = ty;
        moves_d = moves_inc;
        won_d   = (tx == GOAL_X) && (ty == GOAL_Y);
      end
`ifdef BUMP_PENALTY_EN
      else begin
        moves_d = moves_inc;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q    <= START_X;
      py_q    <= START_Y;
      moves_q <= '0;
      won_q   <= 1'b0;
    end else begin
      px_q    <= px_d;
      py_q    <= py_d;
      moves_q <= moves_d;
      won_q   <= won_d;
    end
  end

  always_comb begin
    row    = io.ui_in[ROWSEL_LSB +: 3];
    marker = '0;
    if (py_q == row) marker[px_q] = 1'b1;
  end

  assign io.uo_out = io.ui_in[STATUS_SEL] ? {won_q, moves_q} : (MAZE_ROM[row] ^ marker);

endmodule

// File: tb/tb_micro_maze.sv
// Self-checking bench for micro_maze: reference model feeds a scoreboard queue of expected views.
module tb_micro_maze;

  localparam logic [7:0] ROM [8] = '{8'hF0, 8'hF7, 8'h07, 8'h7F, 8'h7F, 8'h01, 8'hFD, 8'h01};
  localparam logic [3:0] UP = 4'b0001, DN = 4'b0010, LF = 4'b0100, RT = 4'b1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] exp_q [$];

  // Reference state
  int m_px, m_py, m_moves;
  bit m_won;

  micro_maze_if bus ();

  micro_maze dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_view(input logic [3:0] sel);
    logic [7:0] v;
    if (sel[0]) return {m_won, 7'(m_moves)};
    v = ROM[sel[3:1]];
    if (m_py == int'(sel[3:1])) v[m_px] = ~v[m_px];
    return v;
  endfunction

  function automatic void model_reset();
    m_px = 0; m_py = 0; m_moves = 0; m_won = 1'b0;
  endfunction

  function automatic void model_press(input logic [3:0] b);
    int tx, ty;
    if (b[0] && b[1]) begin
      model_reset();
      return;
    end
    if (m_won || $countones(b) != 1) return;
    tx = m_px + (b[3] ? 1 : 0) - (b[2] ? 1 : 0);
    ty = m_py + (b[1] ? 1 : 0) - (b[0] ? 1 : 0);
    if (tx >= 0 && tx < 8 && ty >= 0 && ty < 8 && !ROM[ty][tx]) begin
      m_px = tx; m_py = ty;
      if (m_moves < 127) m_moves++;
      if (tx == 7 && ty == 7) m_won = 1'b1;
    end else begin
`ifdef BUMP_PENALTY_EN
      if (m_moves < 127) m_moves++;
`endif
    end
  endfunction

  // Push the model's expectation, select the view, then pop and compare.
  task automatic view(input string tag, input logic [3:0] sel);
    logic [7:0] got;
    exp_q.push_back(model_view(sel));
    bus.ui_in[7:4] = sel;
    #1;
    got = bus.uo_out;
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: scoreboard empty, got %02h", tag, got);
    end else begin
      check(tag, got, exp_q.pop_front());
    end
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clk);
    bus.ui_in[3:0] = b;
    repeat (3) @(negedge clk);
    bus.ui_in[3:0] = 4'b0;
    repeat (3) @(negedge clk);
    model_press(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.ui_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    bus.ui_in = 8'h00;
    do_reset();

    // Reset state
    view("rst_row0", 4'h0);
    check("rst_row0_lit", bus.uo_out, 8'hF1);
    view("rst_status", 4'h1);
    check("rst_status_lit", bus.uo_out, 8'h00);

    // Blocked at edge and wall
    press(LF);
    view("left_status", 4'h1);
    view("left_row0", 4'h0);
`ifdef BUMP_PENALTY_EN
    check("bump_lit", {1'b0, 7'(m_moves)}, 8'h01);
`endif
    press(UP);
    view("up_status", 4'h1);
    view("up_row0", 4'h0);
    press(DN);
    view("down_wall_status", 4'h1);

    do_reset();
    // Latency: pin rises before edge N, state changes at edge N+2
    @(negedge clk);
    bus.ui_in[7:4] = 4'h1;
    bus.ui_in[3:0] = RT;
    @(negedge clk);
    @(negedge clk);
    #1 check("latency_n1", bus.uo_out, 8'h00);
    @(negedge clk);
    #1 check("latency_n2", bus.uo_out, 8'h01);
    bus.ui_in[3:0] = 4'b0;
    repeat (3) @(negedge clk);
    model_press(RT);
    view("right_row0", 4'h0);
    check("right_row0_lit", bus.uo_out, 8'hF2);
    press(LF | RT);
    view("lr_status", 4'h1);
    view("lr_row0", 4'h0);

    // Solution path
    do_reset();
    repeat (3) press(RT);
    repeat (2) press(DN);
    view("mid_row2", 4'h4);
    repeat (4) press(RT);
    repeat (3) press(DN);
    repeat (6) press(LF);
    repeat (2) press(DN);
    repeat (6) press(RT);
    view("win_status", 4'h1);
    check("win_status_lit", bus.uo_out, 8'h9A);
    view("win_row7", 4'hE);
    check("win_row7_lit", bus.uo_out, 8'h81);
    press(LF);
    press(UP);
    view("won_locked", 4'h1);

    // Restart held
    @(negedge clk);
    bus.ui_in[3:0] = UP | DN;
    repeat (4) @(negedge clk);
    model_reset();
    view("restart_row0", 4'h0);
    view("restart_status", 4'h1);
    bus.ui_in[3:0] = 4'b0;
    repeat (3) @(negedge clk);
    press(RT);
    view("post_restart", 4'h1);

    // Random walk against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      logic [3:0] b;
      b = 4'b1 << $urandom_range(3, 0);
      press(b);
      view($sformatf("rnd_status_%0d", i), 4'h1);
      view($sformatf("rnd_row_%0d", i), {3'(m_py), 1'b0});
    end

    // Asynchronous reset mid-game
    press(RT);
    bus.ui_in[7:4] = 4'h1;
    #3 rst_n = 1'b0;
    #1 model_reset();
    view("async_rst_status", 4'h1);
    view("async_rst_row0", 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
